alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Sequencing controller that shares one 8-bit ALU datapath (ADD/AND/OR class operations on two operand bytes) between two independent requesters. It accepts operand/opcode transactions over valid/ready handshakes, grants the ALU round-robin, registers the result in one execute stage, and returns it on a single tagged response channel with backpressure. It sits between the top-level pin mux (`ui_in`/`uio_in` sources) and the ALU, replacing direct wiring of operands into the adder.

## Interface

Parameters:
- `WIDTH`, default 8: operand and result width.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester N has a transaction.
- `req0_ready` / `req1_ready`  out  1  requester N's transaction is accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operands.
- `req0_op` / `req1_op`  in  2  opcode: 0 ADD, 1 AND, 2 OR, 3 see Configuration.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  requester that issued the op.
- `rsp_data`  out  WIDTH  result.
- `rsp_carry`  out  1  carry-out for ADD/ACC, else 0.
- `busy`  out  1  state is not IDLE.

## Operation

- FSM states: IDLE, EXEC, RESP.
- IDLE: grant computed combinationally from the valids and `last_gnt`. If only one valid is high, it wins. If both are high, the requester not equal to `last_gnt` wins. `reqN_ready` is high only for the winner, and only in IDLE.
- Accept (valid & ready): latch a, b, op and id, update `last_gnt` to id, go to EXEC.
- EXEC: the ALU computes from the latched operands. Register `rsp_data`, `rsp_carry` and `rsp_id`, then go to RESP.
- RESP: `rsp_valid`=1. All rsp_* outputs are held stable until `rsp_ready`=1. On that handshake, go to IDLE.
- Requests arriving during EXEC or RESP see ready=0 and must hold. A requester may change or drop an un-accepted request freely.
- Arithmetic:
  - ADD result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the WIDTH+1-bit sum.
  - AND and OR are bitwise, with carry=0.
- Reset values: `reqN_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_carry`=0, `busy`=0, state=IDLE, `last_gnt`=1 (req0 wins the first tie), accumulator=0.
- Reset asserted mid-transaction aborts it. No response is produced and the accumulator clears.

## Timing

- Accept in cycle N → EXEC in N+1 → `rsp_valid` high in N+2.
- Response handshake in cycle M → IDLE in M+1. The earliest next accept is M+1.
- Minimum issue interval is 3 cycles. `rsp_ready` held high gives one op per 3 cycles.
- `reqN_ready` is combinational from `reqN_valid` and state. There are no combinational paths from `rsp_ready` to any output.

## Configuration

- `ALU_ACC_EN` defined: op 3 = ACC.
  - result = acc + a; carry as ADD; b is ignored.
  - On entering RESP, acc ← result.
  - acc is a single register shared by both requesters.
- `ALU_ACC_EN` undefined: op 3 = bitwise XOR with carry=0. No accumulator register exists.

## Structure

- Package `alu_arb_pkg`:
  - `WIDTH` default constant.
  - Opcode enum `alu_op_t` (OP_ADD, OP_AND, OP_OR, OP_OP3).
  - FSM state enum `arb_state_t`.
- Sub-module `alu_arb_core`: combinational ALU. Inputs a, b, op, acc. Outputs result, carry. The arbiter/FSM lives in `alu_share_arbiter`.

## Test plan

- Reset, then only req0 valid with ADD a=0xF0, b=0x20 → ready0 at cycle 0; 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=0x10, rsp_carry=1.
- req0 and req1 both valid, continuous, rsp_ready=1 → grants alternate 0,1,0,1 with one accept every 3 cycles; req0 wins first after reset.
- rsp_ready held 0 for 5 cycles in RESP with AND 0xCC&0xAA → rsp_data=0x88 stable all 5 cycles; no ready asserted to either requester until after the handshake.
- req1 OR 0x0F|0x30 with rst_n pulsed low during EXEC → rsp_valid stays 0, all outputs at reset values, req0 wins the next tie.
- `ALU_ACC_EN` defined: ACC a=0x05 three times → rsp_data 0x05, 0x0A, 0x0F. Undefined: op 3, a=0xFF, b=0x0F → 0xF0, carry 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared width, opcode and FSM state definitions for the shared-ALU arbiter
package alu_arb_pkg;
    localparam int WIDTH = 8;
    typedef enum logic [1:0] {OP_ADD, OP_AND, OP_OR, OP_OP3} alu_op_t;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} arb_state_t;
endpackage

// File: rtl/alu_arb_core.sv
// alu_arb_core: combinational ADD/AND/OR/op3 ALU; op3 is ACC when ALU_ACC_EN is defined, XOR otherwise
module alu_arb_core
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_acc,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry
);
`ifdef ALU_ACC_EN
    localparam logic ACC = 1'b1;
`else
    localparam logic ACC = 1'b0;
`endif
    logic [WIDTH:0] w_sum;
    logic           w_arith;
    // ACC reuses the adder with the accumulator in place of operand b
    always_comb begin
        w_arith  = i_op == OP_ADD || (ACC && i_op == OP_OP3);
        w_sum    = {1'b0, i_a} + {1'b0, (ACC && i_op == OP_OP3) ? i_acc : i_b};
        o_result = w_arith ? w_sum[WIDTH-1:0] : i_op == OP_AND ? i_a & i_b : i_op == OP_OR ? i_a | i_b : i_a ^ i_b;
        o_carry  = w_arith & w_sum[WIDTH];
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two requesters (ALU_ACC_EN enables the accumulator op)
module alu_share_arbiter #(
    parameter int WIDTH = alu_arb_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             busy
);
    import alu_arb_pkg::*;
    arb_state_t       r_state;
    logic             r_last_gnt;
    logic             r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic             w_idle;
    logic             w_gnt;
    logic             w_accept;
    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;

    // ready is gated by rst_n so both readys read 0 while reset is held
    assign w_idle     = rst_n && r_state == S_IDLE;
    assign w_gnt      = (req0_valid && req1_valid) ? !r_last_gnt : req1_valid;
    assign req0_ready = w_idle && req0_valid && !w_gnt;
    assign req1_ready = w_idle && req1_valid && w_gnt;
    assign w_accept   = req0_ready || req1_ready;
    assign rsp_valid  = r_state == S_RESP;
    assign busy       = r_state != S_IDLE;

    alu_arb_core #(.WIDTH(WIDTH)) u_core (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .i_acc    (w_acc),
        .o_result (w_result),
        .o_carry  (w_carry)
    );

`ifdef ALU_ACC_EN
    logic [WIDTH-1:0] r_acc;
    assign w_acc = r_acc;
    // accumulator captures the ACC result as the FSM enters RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (r_state == S_EXEC && r_op == OP_OP3)
            r_acc <= w_result;
    end
`else
    assign w_acc = '0;
`endif

    // IDLE latches the winner, EXEC registers the ALU result, RESP holds until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last_gnt <= 1'b1;
            r_id       <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_a        <= w_gnt ? req1_a : req0_a;
            r_b        <= w_gnt ? req1_b : req0_b;
            r_op       <= w_gnt ? req1_op : req0_op;
            r_id       <= w_gnt;
            r_last_gnt <= w_gnt;
            r_state    <= S_EXEC;
        end else if (r_state == S_EXEC) begin
            rsp_data   <= w_result;
            rsp_carry  <= w_carry;
            rsp_id     <= r_id;
            r_state    <= S_RESP;
        end else if (r_state == S_RESP && rsp_ready) begin
            r_state    <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench with a behavioural arbitration/ALU model
module tb_alu_share_arbiter;
    logic       clk = 0;
    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, busy;
    logic [7:0] rsp_data;

    typedef struct {int id; int data; int carry; int cyc;} exp_t;
    exp_t q[$];
    int total = 0, bad = 0, cyc = 0;
    int m_last = 1, m_acc = 0;
    bit prev_v = 0;

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string n, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // monitor: predicts grants and results from the rules, compares whatever the DUT presents
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_last = 1;
            m_acc  = 0;
            prev_v = 0;
            check("rst_valid", rsp_valid, 0);
            check("rst_data", rsp_data, 0);
            check("rst_id", rsp_id, 0);
            check("rst_carry", rsp_carry, 0);
            check("rst_busy", busy, 0);
            check("rst_rdy", {req1_ready, req0_ready}, 0);
        end else begin
            check("busy", busy, q.size() != 0);
            if (q.size() != 0) begin
                check("rdy_while_busy", {req1_ready, req0_ready}, 0);
            end else begin
                int w, a, b, op, s, c;
                exp_t e;
                w = (req0_valid && req1_valid) ? (m_last == 0) : req1_valid;
                check("rdy0", req0_ready, req0_valid && w == 0);
                check("rdy1", req1_ready, req1_valid && w == 1);
                if (req0_valid || req1_valid) begin
                    a  = w ? req1_a : req0_a;
                    b  = w ? req1_b : req0_b;
                    op = w ? req1_op : req0_op;
                    c  = 0;
                    case (op)
                        0: begin s = a + b; c = s / 256; end
                        1: s = a & b;
                        2: s = a | b;
                        default: begin
`ifdef ALU_ACC_EN
                            s = m_acc + a;
                            c = s / 256;
                            m_acc = s % 256;
`else
                            s = a ^ b;
`endif
                        end
                    endcase
                    e.id = w; e.data = s % 256; e.carry = c; e.cyc = cyc + 2;
                    q.push_back(e);
                    m_last = w;
                end
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_rsp: got rsp_valid=1 expected no response pending");
                end else begin
                    if (!prev_v) check("latency", cyc, q[0].cyc);
                    check("rsp_id", rsp_id, q[0].id);
                    check("rsp_data", rsp_data, q[0].data);
                    check("rsp_carry", rsp_carry, q[0].carry);
                    if (rsp_ready) void'(q.pop_front());
                end
            end
            prev_v = rsp_valid;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(int n, int a, int b, int op);
        if (n == 0) begin req0_valid = 1; req0_a = 8'(a); req0_b = 8'(b); req0_op = 2'(op); end
        else        begin req1_valid = 1; req1_a = 8'(b == -1 ? a : a); req1_a = 8'(a); req1_b = 8'(b); req1_op = 2'(op); end
    endtask

    task automatic do_reset();
        req0_valid = 0; req1_valid = 0; rst_n = 0;
        tick(2);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; rsp_ready = 1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        tick(3);
        rst_n = 1;
        // single ADD with carry out
        req(0, 8'hF0, 8'h20, 0);
        tick(1); req0_valid = 0;
        tick(4);
        // both requesters continuously valid: alternating grants
        do_reset();
        for (int i = 0; i < 15; i++) begin
            req(0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 2));
            req(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 2));
            tick(1);
        end
        req0_valid = 0; req1_valid = 0;
        tick(4);
        // backpressure in RESP with both requesters waiting
        rsp_ready = 0;
        req(1, 8'hCC, 8'hAA, 1);
        tick(1);
        req(0, 8'h11, 8'h22, 0);
        tick(7);
        rsp_ready = 1;
        tick(1);
        req0_valid = 0; req1_valid = 0;
        tick(5);
        // reset during EXEC aborts the transaction
        do_reset();
        req(1, 8'h0F, 8'h30, 2);
        tick(1);
        req1_valid = 0; rst_n = 0;
        tick(1);
        rst_n = 1;
        req(0, 8'h01, 8'h02, 0);
        req(1, 8'h03, 8'h04, 0);
        tick(1);
        req0_valid = 0; req1_valid = 0;
        tick(4);
        // op3: ACC runs or XOR depending on build
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req(0, 8'h05, $urandom_range(0, 255), 3);
            tick(1); req0_valid = 0;
            tick(3);
        end
        req(1, 8'hFF, 8'h0F, 3);
        tick(1); req1_valid = 0;
        tick(3);
        // random traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 2'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 2'($urandom);
            rsp_ready = $urandom_range(0, 3) != 0;
            tick(1);
        end
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick(1);
        check("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
